raster_bbox_scanner: RTL and testbench

Rasterizer front end that receives one shaded triangle per handshake from the face controller (`data_ready_use` plus three projected vertices). It computes the screen-clipped bounding box and streams every pixel coordinate in that box to the edge-test/depth stage over a valid/ready interface. While scanning it holds the vertex attributes stable for downstream interpolation. When the last pixel has been accepted, it pulses `get_next_triangle` back to the controller to request the next face.

---
 rtl/raster_bbox_scanner_if.sv | 33 +++
 rtl/raster_bbox_scanner.sv | 130 +++++++++++++
 tb/tb_raster_bbox_scanner.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/raster_bbox_scanner_if.sv
// raster_bbox_scanner_if: triangle capture, vertex attribute and pixel stream signals.
// The scanner side uses the master modport; the controller/downstream side uses slave.
interface raster_bbox_scanner_if;
    logic        data_ready_use;
    logic [11:0] vertice1_x_use, vertice1_y_use, vertice2_x_use, vertice2_y_use, vertice3_x_use, vertice3_y_use;
    logic [20:0] vertice1_depth_use, vertice2_depth_use, vertice3_depth_use;
    logic [23:0] vertice1_color_use, vertice2_color_use, vertice3_color_use;
    logic        get_next_triangle, busy, pix_valid, pix_ready, pix_last;
    logic [11:0] pix_x, pix_y;
    logic [11:0] tri_v1_x, tri_v1_y, tri_v2_x, tri_v2_y, tri_v3_x, tri_v3_y;
    logic [20:0] tri_v1_depth, tri_v2_depth, tri_v3_depth;
    logic [23:0] tri_v1_color, tri_v2_color, tri_v3_color;
    modport master (
        input  data_ready_use, pix_ready,
               vertice1_x_use, vertice1_y_use, vertice1_depth_use, vertice1_color_use,
               vertice2_x_use, vertice2_y_use, vertice2_depth_use, vertice2_color_use,
               vertice3_x_use, vertice3_y_use, vertice3_depth_use, vertice3_color_use,
        output get_next_triangle, busy, pix_valid, pix_x, pix_y, pix_last,
               tri_v1_x, tri_v1_y, tri_v1_depth, tri_v1_color,
               tri_v2_x, tri_v2_y, tri_v2_depth, tri_v2_color,
               tri_v3_x, tri_v3_y, tri_v3_depth, tri_v3_color
    );
    modport slave (
        output data_ready_use, pix_ready,
               vertice1_x_use, vertice1_y_use, vertice1_depth_use, vertice1_color_use,
               vertice2_x_use, vertice2_y_use, vertice2_depth_use, vertice2_color_use,
               vertice3_x_use, vertice3_y_use, vertice3_depth_use, vertice3_color_use,
        input  get_next_triangle, busy, pix_valid, pix_x, pix_y, pix_last,
               tri_v1_x, tri_v1_y, tri_v1_depth, tri_v1_color,
               tri_v2_x, tri_v2_y, tri_v2_depth, tri_v2_color,
               tri_v3_x, tri_v3_y, tri_v3_depth, tri_v3_color
    );
endinterface

// File: rtl/raster_bbox_scanner.sv
// raster_bbox_scanner: latches a triangle, clips its bounding box to the screen and
// streams every pixel of the box in raster order, then requests the next triangle.
module raster_bbox_scanner #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input logic clk,
    input logic rst,
    raster_bbox_scanner_if.master b
);
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;
    localparam logic signed [11:0] XLIM = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] YLIM = 12'(SCREEN_H - 1);
    state_t state_q, state_d;
    logic [206:0] tri_q, tri_d, tri_in;
    logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, nx, ny;
    logic pix_valid_q, pix_valid_d, pix_last_q, pix_last_d, gnt_q, gnt_d, busy_q, busy_d;
    logic signed [11:0] x1, y1, x2, y2, x3, y3, mnx, mxx, mny, mxy, bx0, bx1, by0, by1;
    logic empty;
    function automatic logic signed [11:0] lo3(input logic signed [11:0] a, c, d);
        return (a < c && a < d) ? a : (c < d ? c : d);
    endfunction
    function automatic logic signed [11:0] hi3(input logic signed [11:0] a, c, d);
        return (a > c && a > d) ? a : (c > d ? c : d);
    endfunction
    assign tri_in = {b.vertice1_x_use, b.vertice1_y_use, b.vertice1_depth_use, b.vertice1_color_use,
                     b.vertice2_x_use, b.vertice2_y_use, b.vertice2_depth_use, b.vertice2_color_use,
                     b.vertice3_x_use, b.vertice3_y_use, b.vertice3_depth_use, b.vertice3_color_use};
    assign {x1, y1} = tri_q[206:183];
    assign {x2, y2} = tri_q[137:114];
    assign {x3, y3} = tri_q[68:45];
    // Signed box, clipped to the screen; an off-screen triangle yields min > max.
    assign mnx = lo3(x1, x2, x3);
    assign mxx = hi3(x1, x2, x3);
    assign mny = lo3(y1, y2, y3);
    assign mxy = hi3(y1, y2, y3);
    assign bx0 = mnx < 12'sd0 ? 12'sd0 : mnx;
    assign bx1 = mxx > XLIM ? XLIM : mxx;
    assign by0 = mny < 12'sd0 ? 12'sd0 : mny;
    assign by1 = mxy > YLIM ? YLIM : mxy;
    assign empty = bx0 > bx1 || by0 > by1;
    assign nx = pix_x_q == xmax_q ? xmin_q : pix_x_q + 12'd1;
    assign ny = pix_x_q == xmax_q ? pix_y_q + 12'd1 : pix_y_q;
    always_comb begin
        state_d = state_q;
        tri_d = tri_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        pix_valid_d = pix_valid_q;
        pix_last_d = pix_last_q;
        gnt_d = 1'b0;
        busy_d = busy_q;
        case (state_q)
            IDLE: if (b.data_ready_use) begin
                tri_d = tri_in;
                busy_d = 1'b1;
                state_d = SETUP;
            end
            SETUP: begin
                xmin_d = bx0;
                xmax_d = bx1;
                ymin_d = by0;
                ymax_d = by1;
                pix_x_d = bx0;
                pix_y_d = by0;
                pix_valid_d = ~empty;
                pix_last_d = ~empty && bx0 == bx1 && by0 == by1;
                gnt_d = empty;
                state_d = empty ? DONE : SCAN;
            end
            // pix_valid is always high here, so pix_ready alone marks a handshake.
            SCAN: if (b.pix_ready) begin
                pix_x_d = nx;
                pix_y_d = ny;
                pix_valid_d = ~pix_last_q;
                pix_last_d = ~pix_last_q && nx == xmax_q && ny == ymax_q;
                gnt_d = pix_last_q;
                state_d = pix_last_q ? DONE : SCAN;
            end
            DONE: begin
                busy_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tri_q <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q <= 1'b0;
            gnt_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q <= tri_d;
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q <= pix_last_d;
            gnt_q <= gnt_d;
            busy_q <= busy_d;
        end
    end
    assign b.pix_valid = pix_valid_q;
    assign b.pix_x = pix_x_q;
    assign b.pix_y = pix_y_q;
    assign b.pix_last = pix_last_q;
    assign b.get_next_triangle = gnt_q;
    assign b.busy = busy_q;
    assign {b.tri_v1_x, b.tri_v1_y, b.tri_v1_depth, b.tri_v1_color,
            b.tri_v2_x, b.tri_v2_y, b.tri_v2_depth, b.tri_v2_color,
            b.tri_v3_x, b.tri_v3_y, b.tri_v3_depth, b.tri_v3_color} = tri_q;
endmodule

// File: tb/tb_raster_bbox_scanner.sv
// tb_raster_bbox_scanner: scoreboard bench; expected pixels are queued from a box model
// when a triangle is sent and popped against the pixels the DUT hands over.
module tb_raster_bbox_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    raster_bbox_scanner_if b();
    raster_bbox_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (.clk(clk), .rst(rst), .b(b));
    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    logic [206:0] exp_tri;
    int chk = 0, pass = 0;
    int gnt_cyc, gnt_cnt, stall_err, tri_err, valid_cnt, last_cyc;
    bit pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};

    function automatic logic [206:0] in_vec();
        return {b.vertice1_x_use, b.vertice1_y_use, b.vertice1_depth_use, b.vertice1_color_use,
                b.vertice2_x_use, b.vertice2_y_use, b.vertice2_depth_use, b.vertice2_color_use,
                b.vertice3_x_use, b.vertice3_y_use, b.vertice3_depth_use, b.vertice3_color_use};
    endfunction
    function automatic logic [206:0] tri_out();
        return {b.tri_v1_x, b.tri_v1_y, b.tri_v1_depth, b.tri_v1_color,
                b.tri_v2_x, b.tri_v2_y, b.tri_v2_depth, b.tri_v2_color,
                b.tri_v3_x, b.tri_v3_y, b.tri_v3_depth, b.tri_v3_color};
    endfunction

    task automatic drive_tri(input int x1, y1, x2, y2, x3, y3, input bit pulse);
        b.vertice1_x_use = 12'(x1); b.vertice1_y_use = 12'(y1);
        b.vertice2_x_use = 12'(x2); b.vertice2_y_use = 12'(y2);
        b.vertice3_x_use = 12'(x3); b.vertice3_y_use = 12'(y3);
        b.vertice1_depth_use = 21'(x1 * 1000 + y1 + 1);
        b.vertice2_depth_use = 21'(x2 * 1000 + y2 + 2);
        b.vertice3_depth_use = 21'(x3 * 1000 + y3 + 3);
        b.vertice1_color_use = 24'(x1 * 65536 + y1 * 256 + 1);
        b.vertice2_color_use = 24'(x2 * 65536 + y2 * 256 + 2);
        b.vertice3_color_use = 24'(x3 * 65536 + y3 * 256 + 3);
        b.data_ready_use = pulse;
    endtask

    task automatic model_push(input int x1, y1, x2, y2, x3, y3);
        int xa, xb, ya, yb;
        xa = x1 < x2 ? x1 : x2; xa = xa < x3 ? xa : x3; if (xa < 0) xa = 0;
        xb = x1 > x2 ? x1 : x2; xb = xb > x3 ? xb : x3; if (xb > 639) xb = 639;
        ya = y1 < y2 ? y1 : y2; ya = ya < y3 ? ya : y3; if (ya < 0) ya = 0;
        yb = y1 > y2 ? y1 : y2; yb = yb > y3 ? yb : y3; if (yb > 479) yb = 479;
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                exp_q.push_back({12'(x), 12'(y), x == xb && y == yb});
    endtask

    // Returns at the negedge after the capture edge (SETUP cycle).
    task automatic send_tri(input int x1, y1, x2, y2, x3, y3);
        drive_tri(x1, y1, x2, y2, x3, y3, 1'b1);
        exp_tri = in_vec();
        model_push(x1, y1, x2, y2, x3, y3);
        @(negedge clk);
        drive_tri(1, 2, 3, 4, 5, 6, 1'b0);
    endtask

    // Records handshaken pixels and protocol observations; returns in the first IDLE cycle.
    task automatic collect(input int mode, input int inject);
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [11:0] px = '0, py = '0;
        gnt_cyc = -1; gnt_cnt = 0; stall_err = 0; tri_err = 0; valid_cnt = 0; last_cyc = -1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clk);
            if (pv && !pr && (!b.pix_valid || b.pix_x !== px || b.pix_y !== py || b.pix_last !== pl)) stall_err++;
            if (tri_out() !== exp_tri) tri_err++;
            if (b.get_next_triangle) begin
                gnt_cnt++;
                if (gnt_cyc < 0) gnt_cyc = c;
            end
            if (gnt_cyc >= 0 && !b.get_next_triangle && !b.busy) break;
            if (b.pix_valid) valid_cnt++;
            b.pix_ready = (mode == 1 && c >= 1 && c <= 8) ? pat[c - 1] : 1'b1;
            if (c == inject) drive_tri(100, 100, 101, 100, 100, 101, 1'b1);
            else b.data_ready_use = 1'b0;
            if (b.pix_valid && b.pix_ready) begin
                obs_q.push_back({b.pix_x, b.pix_y, b.pix_last});
                last_cyc = c;
            end
            pv = b.pix_valid; pr = b.pix_ready; px = b.pix_x; py = b.pix_y; pl = b.pix_last;
        end
        b.data_ready_use = 1'b0;
        b.pix_ready = 1'b1;
    endtask

    task automatic test_reset;
        drive_tri(0, 0, 0, 0, 0, 0, 1'b0);
        b.pix_ready = 1'b1;
        @(negedge clk);
        chk++; if ({b.busy, b.pix_valid, b.get_next_triangle, b.pix_last, b.pix_x, b.pix_y} !== 28'd0)
            $display("FAIL reset_outputs got busy=%0b valid=%0b gnt=%0b last=%0b x=%0d y=%0d want all 0", b.busy, b.pix_valid, b.get_next_triangle, b.pix_last, b.pix_x, b.pix_y);
        else pass++;
        chk++; if (tri_out() !== 207'd0) $display("FAIL reset_tri got %h want 0", tri_out()); else pass++;
        rst = 1'b0;
        @(negedge clk);
        chk++; if (b.get_next_triangle !== 1'b0) $display("FAIL reset_no_request got %0b want 0", b.get_next_triangle); else pass++;
    endtask

    task automatic test_basic;
        logic [24:0] e, o;
        send_tri(10, 10, 12, 10, 10, 11);
        collect(0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL basic_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0) $display("FAIL basic_extra got %0d extra pixels want 0", obs_q.size()); else pass++;
        obs_q.delete();
        chk++; if (last_cyc != 6) $display("FAIL basic_last_cycle got %0d want 6", last_cyc); else pass++;
        chk++; if (gnt_cyc != 7 || gnt_cnt != 1) $display("FAIL basic_request got cycle %0d count %0d want cycle 7 count 1", gnt_cyc, gnt_cnt); else pass++;
        chk++; if (tri_err != 0) $display("FAIL basic_tri_stable got %0d changes want 0", tri_err); else pass++;
    endtask

    task automatic test_backpressure;
        logic [24:0] e, o;
        send_tri(10, 10, 12, 10, 10, 11);
        collect(1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL bp_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0) $display("FAIL bp_extra got %0d extra pixels want 0", obs_q.size()); else pass++;
        obs_q.delete();
        chk++; if (stall_err != 0) $display("FAIL bp_stall_hold got %0d changes want 0", stall_err); else pass++;
        chk++; if (tri_err != 0) $display("FAIL bp_tri_stable got %0d changes want 0", tri_err); else pass++;
        chk++; if (last_cyc != 9 || gnt_cnt != 1) $display("FAIL bp_timing got last %0d req %0d want last 9 req 1", last_cyc, gnt_cnt); else pass++;
    endtask

    task automatic test_clipping;
        logic [24:0] e, o;
        send_tri(-5, -3, 2, -1, 1, 1);
        collect(0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL clip_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0) $display("FAIL clip_extra got %0d extra pixels want 0", obs_q.size()); else pass++;
        obs_q.delete();
        chk++; if (gnt_cnt != 1) $display("FAIL clip_request got %0d want 1", gnt_cnt); else pass++;
    endtask

    task automatic test_empty_single;
        logic [24:0] e, o;
        send_tri(700, 5, 710, 5, 705, 9);
        collect(0, -1);
        chk++; if (valid_cnt != 0) $display("FAIL empty_valid got %0d valid cycles want 0", valid_cnt); else pass++;
        chk++; if (gnt_cyc != 1 || gnt_cnt != 1) $display("FAIL empty_request got cycle %0d count %0d want cycle 1 count 1", gnt_cyc, gnt_cnt); else pass++;
        chk++; if (obs_q.size() != 0 || exp_q.size() != 0) $display("FAIL empty_pixels got %0d want 0", obs_q.size()); else pass++;
        obs_q.delete();
        send_tri(5, 5, 5, 5, 5, 5);
        collect(0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL single_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0) $display("FAIL single_extra got %0d extra pixels want 0", obs_q.size()); else pass++;
        obs_q.delete();
        chk++; if (gnt_cyc != 2) $display("FAIL single_request got cycle %0d want 2", gnt_cyc); else pass++;
    endtask

    task automatic test_ignored;
        logic [24:0] e, o;
        send_tri(20, 30, 22, 30, 20, 31);
        collect(0, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL ignored_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0) $display("FAIL ignored_extra got %0d extra pixels want 0", obs_q.size()); else pass++;
        obs_q.delete();
        chk++; if (tri_err != 0) $display("FAIL ignored_tri_stable got %0d changes want 0", tri_err); else pass++;
        @(negedge clk);
        chk++; if (b.busy !== 1'b0) $display("FAIL ignored_idle got busy %0b want 0", b.busy); else pass++;
    endtask

    task automatic test_reset_recovery;
        logic [24:0] e, o;
        int gnt_seen = 0;
        send_tri(0, 0, 3, 0, 0, 3);
        exp_q.delete();
        b.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk++; if (b.pix_valid !== 1'b1) $display("FAIL rr_scanning got valid %0b want 1", b.pix_valid); else pass++;
        rst = 1'b1;
        #1;
        chk++; if ({b.busy, b.pix_valid, b.get_next_triangle, b.pix_last, b.pix_x, b.pix_y} !== 28'd0 || tri_out() !== 207'd0)
            $display("FAIL rr_outputs got busy=%0b valid=%0b x=%0d y=%0d want all 0", b.busy, b.pix_valid, b.pix_x, b.pix_y);
        else pass++;
        repeat (2) begin @(negedge clk); if (b.get_next_triangle) gnt_seen++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (b.get_next_triangle) gnt_seen++; end
        chk++; if (gnt_seen != 0) $display("FAIL rr_no_request got %0d pulses want 0", gnt_seen); else pass++;
        send_tri(30, 40, 31, 40, 30, 41);
        collect(0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL rr_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0 || gnt_cnt != 1) $display("FAIL rr_complete got extra %0d req %0d want 0 and 1", obs_q.size(), gnt_cnt); else pass++;
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [24:0] e, o;
        send_tri(1, 1, 2, 1, 1, 1);
        collect(0, -1);
        send_tri(50, 60, 50, 61, 50, 60);
        chk++; if (b.busy !== 1'b1) $display("FAIL b2b_accept got busy %0b want 1", b.busy); else pass++;
        collect(0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = '1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk++; if (o !== e) $display("FAIL b2b_pixel got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)", o[24:13], o[12:1], o[0], e[24:13], e[12:1], e[0]); else pass++;
        end
        chk++; if (obs_q.size() != 0 || gnt_cnt != 1) $display("FAIL b2b_complete got extra %0d req %0d want 0 and 1", obs_q.size(), gnt_cnt); else pass++;
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clipping();
        test_empty_single();
        test_ignored();
        test_reset_recovery();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
